alu_rr_scheduler: RTL



---
 rtl/alu_pkg.sv | 28 ++
 rtl/rr_arbiter_nreq.sv | 30 +++
 rtl/alu_rr_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the round-robin ALU scheduler.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
    OP_MOD  = 4'h4, OP_POW = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_XOR  = 4'h8, OP_NOT = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
    OP_ASR  = 4'hC, OP_MIN = 4'hD, OP_MAX = 4'hE, OP_ASR2 = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } alu_req_t;

  function automatic logic is_slow_op(input logic [3:0] op);
    return (op == 4'h2) || (op == 4'h3) || (op == 4'h4) || (op == 4'h5);
  endfunction

  function automatic logic is_div_zero(input logic [3:0] op, input logic [31:0] b);
    return ((op == 4'h3) || (op == 4'h4)) && (b == 32'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter_nreq.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module rr_arbiter_nreq #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && valid[j]) begin
        grant[j] = 1'b1;
        idx      = IDW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU among NREQ requesters: round-robin grant, one op in flight,
// per-class latency, div/mod-by-zero trapped before issue.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int FAST_LAT = 1,
  parameter int SLOW_LAT = 4,
  parameter int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][3:0]  req_op,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  input  logic [NREQ-1:0][31:0] req_c,
  output logic [3:0]            alu_ctrl,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [31:0]           alu_c,
  input  logic [31:0]           alu_d,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int MAXLAT = (SLOW_LAT > FAST_LAT) ? SLOW_LAT : FAST_LAT;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam logic [CW-1:0] FAST_CNT = CW'(FAST_LAT - 1);
  localparam logic [CW-1:0] SLOW_CNT = CW'(SLOW_LAT - 1);

  sched_state_e    state;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   cnt;
  alu_req_t        req_q;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic [3:0]      win_op;
  logic [31:0]     win_b;

  rr_arbiter_nreq #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign win_op    = req_op[win_idx];
  assign win_b     = req_b[win_idx];
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign busy      = (state != IDLE);

  // ALU inputs come straight from the issue register so they stay frozen through EXEC
  assign alu_ctrl = req_q.op;
  assign alu_a    = req_q.a;
  assign alu_b    = req_q.b;
  assign alu_c    = req_q.c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_any) begin
          rsp_id <= win_idx;
          // Trapped ops skip the ALU entirely; its inputs keep the last issued op
          if (is_div_zero(win_op, win_b)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            req_q <= '{op: win_op, a: req_a[win_idx], b: win_b, c: req_c[win_idx]};
            cnt   <= is_slow_op(win_op) ? SLOW_CNT : FAST_CNT;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= alu_d;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
          rr_ptr    <= (int'(rsp_id) == NREQ - 1) ? '0 : rsp_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
